// File: rtl/pingpong_fill_ctrl.sv
// pingpong_fill_ctrl: write-side sequencer for two ping-pong frame buffers.
// Accepts a valid/ready pixel stream, writes whole frames alternately into
// buffer 0 and buffer 1, and tracks which buffers hold an unread frame.
module pingpong_fill_ctrl #(
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CSWrite,
    input  logic [9:0]        AIPOut,
    input  logic [9:0]        AILOut,
    input  logic              PixValid,
    output logic              PixReady,
    output logic              WE0,
    output logic              WE1,
    output logic [ADDR_W-1:0] WAddr,
    input  logic              Rel0,
    input  logic              Rel1,
    output logic              Buf0Full,
    output logic              Buf1Full,
    output logic              FrameDone
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL0,
        ST_FILL1,
        ST_WAIT
    } state_e;

    state_e              state_q, state_d;
    logic                target_q, target_d;
    logic                buf0_full_q, buf0_full_d;
    logic                buf1_full_q, buf1_full_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]   frame_len_q, frame_len_d;

    logic [19:0]         prod20;
    logic [ADDR_W-1:0]   frame_len_new;
    logic                len_zero;
    logic                pix_ready;
    logic                beat;
    logic                last_beat;
    logic                target_full;
    logic                other_full;

    // Frame length candidate and handshake decode
    always_comb begin
        prod20        = {10'd0, AIPOut} * {10'd0, AILOut};
        frame_len_new = ADDR_W'(prod20);
        len_zero      = (prod20 == 20'd0);
        pix_ready     = (state_q == ST_FILL0) || (state_q == ST_FILL1);
        beat          = PixValid && pix_ready;
        last_beat     = beat && (waddr_q == (frame_len_q - ADDR_W'(1)));
        target_full   = target_q ? buf1_full_q : buf0_full_q;
        // target_q always names the buffer being filled while in FILLn
        other_full    = target_q ? buf0_full_q : buf1_full_q;
    end

    // Next-state logic: sequencing, address counting and full-flag tracking
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        buf0_full_d  = buf0_full_q;
        buf1_full_d  = buf1_full_q;
        waddr_d      = waddr_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;

        // Releases first so that a last-beat set below takes priority
        if (Rel0 && (state_q != ST_FILL0)) buf0_full_d = 1'b0;
        if (Rel1 && (state_q != ST_FILL1)) buf1_full_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CSWrite && !len_zero) begin
                    if (target_full) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d     = target_q ? ST_FILL1 : ST_FILL0;
                        frame_len_d = frame_len_new;
                    end
                end
            end
            ST_FILL0, ST_FILL1: begin
                if (beat) begin
                    if (!last_beat) begin
                        waddr_d = waddr_q + ADDR_W'(1);
                    end else begin
                        waddr_d      = '0;
                        frame_done_d = 1'b1;
                        target_d     = ~target_q;
                        if (state_q == ST_FILL0) buf0_full_d = 1'b1;
                        else                     buf1_full_d = 1'b1;
                        if (!CSWrite || len_zero) begin
                            state_d = ST_IDLE;
                        end else if (other_full) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d     = target_q ? ST_FILL0 : ST_FILL1;
                            frame_len_d = frame_len_new;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (!CSWrite) begin
                    state_d = ST_IDLE;
                end else if (!target_full && !len_zero) begin
                    state_d     = target_q ? ST_FILL1 : ST_FILL0;
                    frame_len_d = frame_len_new;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            target_q     <= 1'b0;
            buf0_full_q  <= 1'b0;
            buf1_full_q  <= 1'b0;
            waddr_q      <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            buf0_full_q  <= buf0_full_d;
            buf1_full_q  <= buf1_full_d;
            waddr_q      <= waddr_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign PixReady  = pix_ready;
    assign WE0       = beat && (state_q == ST_FILL0);
    assign WE1       = beat && (state_q == ST_FILL1);
    assign WAddr     = waddr_q;
    assign Buf0Full  = buf0_full_q;
    assign Buf1Full  = buf1_full_q;
    assign FrameDone = frame_done_q;

endmodule
